uart_tx_frame: RTL

UART transmit framer: the sending end of the team's serial link, producing frames that the receive-side start detector and deserializer consume. Accepts bytes over a valid/ready handshake into a one-entry holding buffer, then serializes each byte at a fixed bit period. Frame order: one start bit (0), 8 data bits LSB first, optional parity, one stop bit (1). The line idles high.

---
 rtl/uart_tx_frame.sv | 100 ++++++++++
 1 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmit framer: start, 8 data LSB first, optional parity, stop
module uart_tx_frame #(
   parameter int CLKS_PER_BIT = 16,
   parameter bit PARITY_EN    = 1'b1,
   parameter bit PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data_in,
   input  logic       load,
   output logic       ready,
   output logic       busy,
   output logic       done,
   output logic       txout
);
   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [7:0]    hold, hold_nxt;
   logic          hold_full, hold_full_nxt;
   logic          txout_nxt;
   logic          accept, bit_end, frame_end;

   assign accept    = load && !hold_full;
   assign bit_end   = (cnt == CNT_LAST);
   assign frame_end = (state == STOP) && bit_end;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         txout     <= 1'b1;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shreg     <= shreg_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
         txout     <= txout_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
      idx_nxt       = idx;
      shreg_nxt     = shreg;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      case (state)
         IDLE:    if (accept) state_nxt = START;
         START:   if (bit_end) state_nxt = DATA;
         DATA: begin
            if (bit_end) begin
               idx_nxt = idx + 3'd1;
               if (idx == 3'd7) state_nxt = PARITY_EN ? PARITY : STOP;
            end
         end
         PARITY:  if (bit_end) state_nxt = STOP;
         STOP:    if (bit_end) state_nxt = (hold_full || accept) ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
      // A byte bypasses the buffer whenever the shifter is free to take it this edge.
      if (accept) begin
         if (state == IDLE || frame_end) begin
            shreg_nxt = data_in;
         end else begin
            hold_nxt      = data_in;
            hold_full_nxt = 1'b1;
         end
      end else if (frame_end && hold_full) begin
         shreg_nxt     = hold;
         hold_full_nxt = 1'b0;
      end
   end

   // txout is registered from next-state values so the line matches state without a lag.
   always_comb begin
      ready = !hold_full;
      busy  = (state != IDLE);
      done  = frame_end;
      case (state_nxt)
         START:   txout_nxt = 1'b0;
         DATA:    txout_nxt = shreg_nxt[idx_nxt];
         PARITY:  txout_nxt = (^shreg_nxt) ^ PARITY_ODD;
         default: txout_nxt = 1'b1;
      endcase
   end
endmodule
